// File: rtl/mips_isa_pkg.sv
// Shared ISA constants: opcode encodings, instruction field positions, default widths.
// No logic, so no latency.
// No handshake of its own, so no backpressure.
package mips_isa_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int IMM_W_DEF = 16;

  // Field positions inside the 32-bit instruction word
  localparam int OP_LSB  = 26;
  localparam int OP_W    = 6;
  localparam int SRC_LSB = 21;
  localparam int TGT_LSB = 16;
  localparam int RD_LSB  = 11;

  typedef enum logic [5:0] {
    OP_ADDU = 6'd1,
    OP_BEQ  = 6'd2,
    OP_LW   = 6'd3,
    OP_MULT = 6'd4,
    OP_ADDI = 6'd5,
    OP_J    = 6'd6,
    OP_NOP  = 6'd7
  } opcode_e;

  // Anything outside 1..7 is decoded as a nop and flagged illegal
  function automatic logic is_legal(input logic [5:0] op);
    return (op >= 6'd1) && (op <= 6'd7);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the decode stage's handshake, writeback and decoded-output signals.
// Pure wiring, no latency.
// Backpressure is carried by in_ready/out_ready; the interface adds none.
interface decode_stage_if #(
  parameter int XLEN = mips_isa_pkg::XLEN_DEF,
  parameter int NREG = mips_isa_pkg::NREG_DEF
);
  localparam int RAW = $clog2(NREG);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] pc_i;
  logic            wb_en;
  logic [RAW-1:0]  wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opcode;
  logic [RAW-1:0]  dest;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] sign_e;
  logic [XLEN-1:0] pc_o;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal;

  // Decode stage side
  modport slave (
    input  in_valid, ir, pc_i, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, opcode, dest, a, b, sign_e, pc_o,
           redirect, redirect_pc, illegal
  );

  // Fetch / writeback / execute side
  modport master (
    output in_valid, ir, pc_i, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, opcode, dest, a, b, sign_e, pc_o,
           redirect, redirect_pc, illegal
  );

endinterface

// File: rtl/reg_file_2r1w.sv
// NREG x XLEN register file, two combinational read ports, one write port, R0 hardwired to 0.
// Reads are same-cycle; a write lands on the next edge but is forwarded to matching reads at once.
// No backpressure: a write is always taken.
module reg_file_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we_i,
  input  logic [RAW-1:0]  waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RAW-1:0]  raddr0_i,
  input  logic [RAW-1:0]  raddr1_i,
  output logic [XLEN-1:0] rdata0_o,
  output logic [XLEN-1:0] rdata1_o
);

  logic [XLEN-1:0] mem_q [NREG];

  // Storage: reset wipes every entry; writes to R0 are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with write-through bypass; R0 always reads 0
  always_comb begin
    rdata0_o = '0;
    rdata1_o = '0;
    if (raddr0_i != '0)
      rdata0_o = (we_i && (waddr_i == raddr0_i)) ? wdata_i : mem_q[raddr0_i];
    if (raddr1_i != '0)
      rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, operand read, scoreboard hazard check, branch resolve.
// Latency 1: an accepted instruction appears on the outputs at the next edge.
// Holds the bundle while out_ready is low; in_ready drops on stall, hazard, redirect or flush.
module decode_stage
  import mips_isa_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int IMM_W = IMM_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);
  localparam int RAW = $clog2(NREG);

  // Decoded fields of the offered instruction
  logic [5:0]      op_raw;
  logic [5:0]      op_eff;
  logic            legal;
  logic [RAW-1:0]  src, tgt, rd;
  logic            use_src, use_tgt, use_imm;
  logic [RAW-1:0]  dest_dec;
  logic [XLEN-1:0] imm_ext, sign_e_dec, a_dec, b_dec, rdata0, rdata1;
  logic            hazard, take, in_ready, accept;

  // Output bundle and scoreboard state
  logic            out_valid_q, out_valid_d;
  logic            redirect_q, redirect_d;
  logic            illegal_q, illegal_d;
  logic [5:0]      opcode_q, opcode_d;
  logic [RAW-1:0]  dest_q, dest_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, sign_e_q, sign_e_d;
  logic [XLEN-1:0] pc_q, pc_d, redirect_pc_q, redirect_pc_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign op_raw  = bus.ir[OP_LSB +: OP_W];
  assign legal   = is_legal(op_raw);
  assign op_eff  = legal ? op_raw : OP_NOP;
  assign src     = bus.ir[SRC_LSB +: RAW];
  assign tgt     = bus.ir[TGT_LSB +: RAW];
  assign rd      = bus.ir[RD_LSB +: RAW];
  assign imm_ext = {{(XLEN-IMM_W){bus.ir[IMM_W-1]}}, bus.ir[IMM_W-1:0]};

  reg_file_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data),
    .raddr0_i (src),
    .raddr1_i (tgt),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  // Per-opcode operand usage, destination and immediate selection
  always_comb begin
    use_src  = 1'b0;
    use_tgt  = 1'b0;
    use_imm  = 1'b0;
    dest_dec = '0;
    case (op_eff)
      OP_ADDU, OP_MULT: begin use_src = 1'b1; use_tgt = 1'b1; dest_dec = rd; end
      OP_BEQ:           begin use_src = 1'b1; use_tgt = 1'b1; use_imm = 1'b1; end
      OP_LW, OP_ADDI:   begin use_src = 1'b1; use_imm = 1'b1; dest_dec = tgt; end
      OP_J:             begin use_imm = 1'b1; end
      default: ;
    endcase
  end

  assign a_dec      = use_src ? rdata0 : '0;
  assign b_dec      = use_tgt ? rdata1 : '0;
  assign sign_e_dec = use_imm ? imm_ext : '0;

  // A source in flight is still safe if its writeback lands this very cycle (bypass)
  assign hazard = (use_src && (src != '0) && busy_q[src] && !(bus.wb_en && (bus.wb_addr == src))) ||
                  (use_tgt && (tgt != '0) && busy_q[tgt] && !(bus.wb_en && (bus.wb_addr == tgt)));

  assign take     = ((op_eff == OP_BEQ) && (a_dec == b_dec)) || (op_eff == OP_J);
  assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !redirect_q && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  // Output slot next state: flush kills, accept loads, consumption empties, else hold
  always_comb begin
    out_valid_d   = out_valid_q;
    redirect_d    = 1'b0;
    illegal_d     = illegal_q;
    opcode_d      = opcode_q;
    dest_d        = dest_q;
    a_d           = a_q;
    b_d           = b_q;
    sign_e_d      = sign_e_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      redirect_d    = take;
      illegal_d     = !legal;
      opcode_d      = op_raw;
      dest_d        = dest_dec;
      a_d           = a_dec;
      b_d           = b_dec;
      sign_e_d      = sign_e_dec;
      pc_d          = bus.pc_i;
      redirect_pc_d = bus.pc_i + sign_e_dec;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Scoreboard: writeback clears, a flushed bundle returns its bit, acceptance sets (set wins)
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;
    if (bus.flush && out_valid_q && (dest_q != '0)) busy_d[dest_q] = 1'b0;
    if (accept && (dest_dec != '0)) busy_d[dest_dec] = 1'b1;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      redirect_q    <= 1'b0;
      illegal_q     <= 1'b0;
      opcode_q      <= '0;
      dest_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sign_e_q      <= '0;
      pc_q          <= '0;
      redirect_pc_q <= '0;
      busy_q        <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      redirect_q    <= redirect_d;
      illegal_q     <= illegal_d;
      opcode_q      <= opcode_d;
      dest_q        <= dest_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sign_e_q      <= sign_e_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.redirect    = redirect_q;
  assign bus.illegal     = illegal_q;
  assign bus.opcode      = opcode_q;
  assign bus.dest        = dest_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.sign_e      = sign_e_q;
  assign bus.pc_o        = pc_q;
  assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two).
REQ-003 SHALL have parameter IMM_W, default 16, immediate field width (ir[IMM_W-1:0]).
REQ-004 SHALL derive RAW = log2(NREG).
REQ-005 Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this cycle
- ir, pc_i  in  XLEN  instruction, its PC
- wb_en  in  1  writeback strobe
- wb_addr  in  RAW  writeback register
- wb_data  in  XLEN  writeback value
- flush  in  1  kill output slot
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- opcode  out  6  ir[31:26]
- dest  out  RAW  destination, 0 if none
- a, b, sign_e, pc_o  out  XLEN  operands, extended immediate, PC
- redirect  out  1  taken-branch/jump pulse
- redirect_pc  out  XLEN  branch target
- illegal  out  1  unknown opcode flag

Function
REQ-006 Opcodes SHALL be addu=1, beq=2, lw=3, mult=4, addi=5, j=6, nop=7; src=ir[25:21], tgt=ir[20:16], rd=ir[15:11], each truncated to RAW bits.
REQ-007 The internal register file SHALL be NREG x XLEN, 2 read / 1 write; R0 reads 0; writes to R0 are ignored.
REQ-008 A same-cycle write to a register being read SHALL return wb_data (write-through bypass).
REQ-009 Sources used: addu/beq/mult read src and tgt; lw/addi read src; j/nop read none. Unused a/b outputs SHALL be 0.
REQ-010 Destinations: addu/mult use rd; lw/addi use tgt; all others use 0.
REQ-011 sign_e SHALL be ir[IMM_W-1:0] sign-extended to XLEN for beq/lw/addi/j; otherwise 0.
REQ-012 A scoreboard of NREG busy bits SHALL set busy[dest] when an instruction with dest != 0 is accepted, and clear busy[wb_addr] on wb_en; a simultaneous set and clear of the same register SHALL leave it set.
REQ-013 Hazard SHALL assert when a used source (nonzero) is busy and not being written this cycle.
REQ-014 in_ready SHALL be (!out_valid || out_ready) && !hazard && !redirect && !flush.
REQ-015 Acceptance (in_valid && in_ready) SHALL load all outputs on the next edge (latency 1); outputs SHALL hold while out_valid && !out_ready.
REQ-016 beq with a==b, and j always, SHALL assert redirect for exactly one cycle, coincident with out_valid of that instruction, with redirect_pc = pc_i + sign_e (modulo 2^XLEN).
REQ-017 During the redirect cycle no instruction SHALL be accepted.
REQ-018 An opcode outside 1..7 SHALL pass through as nop with dest=0 and illegal=1.
REQ-019 flush SHALL clear out_valid and redirect on the next edge and clear the busy bit set by the flushed bundle; busy bits of bundles already consumed downstream SHALL be unaffected.

Reset
REQ-020 reset SHALL clear out_valid, redirect, illegal, the scoreboard, every register-file entry, and every data output to 0.
REQ-021 Reset asserted mid-stall SHALL discard the stalled instruction; the first post-reset acceptance requires a fresh in_valid.

Structure
REQ-022 Opcode constants, field positions and default parameters SHALL reside in shared package mips_isa_pkg.
REQ-023 The register file SHALL be a sub-module reg_file_2r1w (parameterised by XLEN and NREG, with bypass); scoreboard and handshake logic SHALL stay in decode_stage.

Verification
REQ-024 addi r1,r0,5 followed by addu r2,r1,r1 with no writeback -> addu held with in_ready=0; wb_en r1=5 -> addu accepted the same cycle with a=b=5.
REQ-025 beq r3,r3,imm=0xFFFC at pc 0x40 -> redirect=1 for one cycle, redirect_pc=0x3C, in_ready=0 in that cycle.
REQ-026 With out_ready=0 for 3 cycles after acceptance -> outputs stable, in_ready=0, no second acceptance.
REQ-027 Write r0=0xDEAD, then addu reading r0 -> a=0, and no scoreboard stall on r0.
REQ-028 opcode 0x3F -> illegal=1, dest=0, no redirect; flush on the following cycle -> out_valid=0 next edge.
REQ-029 reset pulse while addu is stalled -> all outputs 0, scoreboard empty, a reread register returns 0.
